parallel_in: RTL and testbench

PARALLEL_IN -- requirements
Module: parallel_in

---
 rtl/parallel_in_if.sv | 30 +++
 rtl/parallel_in.sv | 105 ++++++++++
 tb/tb_parallel_in.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parallel_in_if.sv
// CPU read bus between the processor/data-RAM side and the parallel input block.
//   Address : CPU word address (15 bits)
//   re      : read strobe, one cycle per read
//   RamData : data RAM read output, valid one cycle after its address
//   DataIn  : read data returned to the CPU
//   rden    : RAM read enable
// master = CPU/RAM side, slave = parallel_in.
interface parallel_in_if;
  logic [14:0] Address;
  logic        re;
  logic [15:0] RamData;
  logic [15:0] DataIn;
  logic        rden;

  modport master (
    output Address,
    output re,
    output RamData,
    input  DataIn,
    input  rden
  );

  modport slave (
    input  Address,
    input  re,
    input  RamData,
    output DataIn,
    output rden
  );
endinterface

// File: rtl/parallel_in.sv
// Two 16-bit debounced parallel input ports mapped into the top of the CPU address space.
//   clk   : system clock, all state on rising edge
//   rst   : synchronous active-high reset
//   PinsA : asynchronous external input port A
//   PinsB : asynchronous external input port B
//   bus   : CPU read bus (slave side), see parallel_in_if
//   irq   : high while either change flag is set
// Window 0x7FFC..0x7FFF: port A, port B, status {14'b0, chgB, chgA}, reserved (reads 0).
// Reads inside the window return one cycle later, matching the RAM latency; reads outside it
// pass RamData through.
module parallel_in #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         PinsA,
  input  logic [15:0]         PinsB,
  parallel_in_if.slave        bus,
  output logic                irq
);

  localparam logic [7:0] CntLast = 8'(DEBOUNCE - 1);

  // Index 0 is port A, index 1 is port B.
  logic [1:0][15:0] pins;
  logic [1:0][15:0] sync1_q, sync2_q;
  logic [1:0][15:0] deb_q, deb_d;
  logic [1:0][7:0]  cnt_q, cnt_d;
  logic [1:0]       chg_q, chg_d;
  logic [1:0]       load;
  logic [1:0]       clr;
  logic             in_win;
  logic             sel_q, sel_d;
  logic [15:0]      port_q, port_d;

  assign pins   = {PinsB, PinsA};
  assign in_win = (bus.Address[14:2] == 13'h1FFF);
  assign bus.rden = bus.re & ~in_win;

  // Debounce: the counter runs while the synced word differs from the debounced word, whatever
  // that differing value is; the word present on the final counted edge is the one loaded.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    load  = '0;
    for (int p = 0; p < 2; p++) begin
      if (sync2_q[p] == deb_q[p]) begin
        cnt_d[p] = 8'd0;
      end else if (cnt_q[p] == CntLast) begin
        deb_d[p] = sync2_q[p];
        cnt_d[p] = 8'd0;
        load[p]  = 1'b1;
      end else begin
        cnt_d[p] = cnt_q[p] + 8'd1;
      end
    end
  end

  // A load always carries a value different from the old one, so load alone sets the flag.
  // Set takes priority over a coincident clearing read.
  always_comb begin
    clr[0] = bus.re && (bus.Address == 15'h7FFC);
    clr[1] = bus.re && (bus.Address == 15'h7FFD);
    chg_d  = load | (chg_q & ~clr);
  end

  // Read capture uses the pre-update debounced values and flags.
  always_comb begin
    sel_d  = sel_q;
    port_d = port_q;
    if (bus.re) begin
      sel_d = in_win;
      unique case (bus.Address[1:0])
        2'd0:    port_d = deb_q[0];
        2'd1:    port_d = deb_q[1];
        2'd2:    port_d = {14'b0, chg_q[1], chg_q[0]};
        default: port_d = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
      chg_q   <= '0;
      sel_q   <= 1'b0;
      port_q  <= 16'h0000;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      chg_q   <= chg_d;
      sel_q   <= sel_d;
      port_q  <= port_d;
    end
  end

  assign bus.DataIn = sel_q ? port_q : bus.RamData;
  assign irq        = |chg_q;

endmodule

// File: tb/tb_parallel_in.sv
module tb_parallel_in;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] PinsA = '0;
  logic [15:0] PinsB = '0;
  logic [14:0] addr = '0;
  logic        re = 1'b0;
  logic [15:0] ram = '0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  parallel_in_if bus ();
  assign bus.Address = addr;
  assign bus.re      = re;
  assign bus.RamData = ram;

  parallel_in #(.DEBOUNCE(DEB)) dut (
    .clk   (clk),
    .rst   (rst),
    .PinsA (PinsA),
    .PinsB (PinsB),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Reference model: pins seen two edges late; a port accepts a new value once DEB successive
  // samples have all disagreed with the accepted value.
  logic [15:0] m_pin_d1[2], m_pin_d2[2], m_deb[2];
  int          m_run[2];
  logic        m_chg[2];
  logic        m_sel;
  logic [15:0] m_port;

  task automatic model_edge();
    logic [15:0] nd[2];
    int          nr[2];
    logic        acc[2];
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        m_pin_d1[p] = '0; m_pin_d2[p] = '0; m_deb[p] = '0; m_run[p] = 0; m_chg[p] = 1'b0;
      end
      m_sel = 1'b0;
      m_port = '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        nd[p] = m_deb[p];
        acc[p] = 1'b0;
        nr[p] = 0;
        if (m_pin_d2[p] != m_deb[p]) begin
          nr[p] = m_run[p] + 1;
          if (nr[p] >= DEB) begin
            nd[p] = m_pin_d2[p];
            nr[p] = 0;
            acc[p] = 1'b1;
          end
        end
      end
      if (re) begin
        m_sel = (addr >= 15'h7FFC);
        case (addr)
          15'h7FFC: m_port = m_deb[0];
          15'h7FFD: m_port = m_deb[1];
          15'h7FFE: m_port = {14'b0, m_chg[1], m_chg[0]};
          15'h7FFF: m_port = 16'h0000;
          default:  m_port = m_port;
        endcase
      end
      m_chg[0] = acc[0] | (m_chg[0] & !(re && addr == 15'h7FFC));
      m_chg[1] = acc[1] | (m_chg[1] & !(re && addr == 15'h7FFD));
      for (int p = 0; p < 2; p++) begin
        m_deb[p] = nd[p];
        m_run[p] = nr[p];
        m_pin_d2[p] = m_pin_d1[p];
      end
      m_pin_d1[0] = PinsA;
      m_pin_d1[1] = PinsB;
    end
  endtask

  // One clock edge; returns at the following falling edge, where outputs are sampled.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    re = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Single-cycle read; returns DataIn sampled after the capturing edge.
  task automatic do_read(input logic [14:0] a, output logic [15:0] d);
    addr = a;
    re = 1'b1;
    tick();
    re = 1'b0;
    d = bus.DataIn;
  endtask

  task automatic test_reset();
    PinsA = 16'hFFFF;
    PinsB = 16'hAAAA;
    ram = 16'hBEEF;
    re = 1'b1;
    addr = 15'h7FFC;
    rst = 1'b1;
    tick(3);
    checks++;
    if (bus.DataIn !== 16'hBEEF) begin
      errors++; $display("FAIL reset_datain got %h want %h", bus.DataIn, 16'hBEEF);
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    checks++;
    if (bus.rden !== 1'b0) begin errors++; $display("FAIL reset_rden_win got %b want 0", bus.rden); end
    addr = 15'h1234;
    #1;
    checks++;
    if (bus.rden !== 1'b1) begin errors++; $display("FAIL reset_rden_ram got %b want 1", bus.rden); end
    re = 1'b0;
    PinsA = '0;
    PinsB = '0;
    tick();
  endtask

  task automatic test_latency();
    logic [15:0] d;
    PinsA = 16'h00FF;
    PinsB = 16'h0000;
    do_reset();
    tick(5);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL latency_early_irq got %b want 0", irq); end
    tick();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL latency_irq got %b want 1", irq); end
    addr = 15'h7FFC;
    re = 1'b1;
    #1;
    checks++;
    if (bus.rden !== 1'b0) begin errors++; $display("FAIL read_a_rden got %b want 0", bus.rden); end
    do_read(15'h7FFC, d);
    checks++;
    if (d !== 16'h00FF) begin errors++; $display("FAIL read_a_data got %h want %h", d, 16'h00FF); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL read_a_irqclr got %b want 0", irq); end
  endtask

  task automatic test_glitch();
    logic [15:0] d;
    PinsA = '0;
    PinsB = '0;
    do_reset();
    tick(2);
    PinsB = 16'h0001;
    tick(3);
    PinsB = 16'h0000;
    tick(8);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq got %b want 0", irq); end
    do_read(15'h7FFD, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL glitch_b got %h want 0000", d); end
    do_read(15'h7FFE, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL glitch_status got %h want 0000", d); end
  endtask

  task automatic test_status();
    logic [15:0] d;
    PinsA = 16'h0005;
    PinsB = 16'h0003;
    do_reset();
    tick(8);
    do_read(15'h7FFE, d);
    checks++;
    if (d !== 16'h0003) begin errors++; $display("FAIL status_read got %h want 0003", d); end
    do_read(15'h7FFE, d);
    checks++;
    if (d !== 16'h0003) begin errors++; $display("FAIL status_keep got %h want 0003", d); end
    do_read(15'h7FFF, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL reserved got %h want 0000", d); end
    ram = 16'h5A5A;
    addr = 15'h1234;
    re = 1'b1;
    #1;
    checks++;
    if (bus.rden !== 1'b1) begin errors++; $display("FAIL ram_rden got %b want 1", bus.rden); end
    tick();
    re = 1'b0;
    ram = 16'hC3C3;
    #1;
    checks++;
    if (bus.DataIn !== 16'hC3C3) begin
      errors++; $display("FAIL ram_passthru got %h want %h", bus.DataIn, 16'hC3C3);
    end
  endtask

  task automatic test_read_vs_load();
    logic [15:0] d;
    PinsA = '0;
    PinsB = 16'h1111;
    do_reset();
    tick(10);
    do_read(15'h7FFD, d); // clears chgB, B = 1111
    PinsB = 16'h0A5A;
    tick(5);
    do_read(15'h7FFD, d); // lands on the loading edge
    checks++;
    if (d !== 16'h1111) begin errors++; $display("FAIL same_edge_old got %h want 1111", d); end
    do_read(15'h7FFE, d);
    checks++;
    if (d !== 16'h0002) begin errors++; $display("FAIL same_edge_chgb got %h want 0002", d); end
    do_read(15'h7FFD, d);
    checks++;
    if (d !== 16'h0A5A) begin errors++; $display("FAIL same_edge_new got %h want 0A5A", d); end
  endtask

  task automatic test_reset_mid_debounce();
    PinsA = '0;
    PinsB = '0;
    do_reset();
    tick(3);
    PinsA = 16'h1234;
    tick(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(5);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL midreset_early got %b want 0", irq); end
    tick();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL midreset_load got %b want 1", irq); end
  endtask

  task automatic test_random();
    logic [15:0] exp_d;
    PinsA = '0;
    PinsB = '0;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 5) == 0) PinsA = 16'($urandom);
      if ($urandom_range(0, 5) == 0) PinsB = 16'($urandom);
      rst  = ($urandom_range(0, 199) == 0);
      re   = ($urandom_range(0, 2) == 0);
      addr = $urandom_range(0, 1) ? 15'(15'h7FFC + 15'($urandom_range(0, 3))) : 15'($urandom);
      ram  = 16'($urandom);
      #1;
      exp_d = m_sel ? m_port : ram;
      checks++;
      if (bus.DataIn !== exp_d) begin
        errors++; $display("FAIL rand_datain cyc %0d got %h want %h", c, bus.DataIn, exp_d);
      end
      checks++;
      if (bus.rden !== (re && addr < 15'h7FFC)) begin
        errors++; $display("FAIL rand_rden cyc %0d got %b", c, bus.rden);
      end
      checks++;
      if (irq !== (m_chg[0] | m_chg[1])) begin
        errors++; $display("FAIL rand_irq cyc %0d got %b want %b", c, irq, m_chg[0] | m_chg[1]);
      end
      tick();
    end
    rst = 1'b0;
    re = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_glitch();
    test_status();
    test_read_vs_load();
    test_reset_mid_debounce();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
